register_file: RTL and testbench
================================

Name: register_file

Overview:
- 16-entry x 32-bit general-purpose register file for the pipelined RISC core, sitting between the decode stage and writeback.
- Provides two registered read ports (rs, rt) and one write port (rd, or the hard-wired link register R14 for CLL).
- Flags the odd-destination exception for the double-word instructions LDW and SDW.

Parameters:
- none. Data width is fixed at 32, register count at 16, address width at 4, and the link register index at 14.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- reg_read  input  1  read enable for both read ports
- rs  input  4  read port 1 address
- rt  input  4  read port 2 address
- rd  input  4  write address (normal writes)
- reg_write  input  1  write enable
- reg_write_addr_sel  input  1  1: write return_addr to R14 (CLL); 0: write write_data to R[rd]
- stall  input  1  pipeline stall; freezes all state
- opcode  input  6  opcode of the instruction in decode; used for exception detection only
- write_data  input  32  writeback data
- return_addr  input  32  link address for CLL
- read_data1  output  32  registered R[rs]
- read_data2  output  32  registered R[rt]
- exception  output  1  odd-Rd exception for LDW/SDW

Behaviour:
- Reset (asynchronous, while reset=1): R0..R15 = 0, read_data1 = 0, read_data2 = 0, exception = 0.
- R0 is hard-wired zero: it always reads 0 and writes to it are discarded.
- Exception (combinational, outside reset): exception = 1 iff opcode==8 (LDW) or opcode==9 (SDW), and rd[0]==1. It is independent of reg_write and stall.
- Write (rising edge, reset=0): occurs when reg_write=1, stall=0 and exception=0.
  - If reg_write_addr_sel=1: R14 <= return_addr (rd is ignored).
  - Else: R[rd] <= write_data (suppressed if rd==0).
- Write suppression: an exception cycle never modifies any register.
- Read (rising edge, reset=0): when reg_read=1 and stall=0, read_data1 <= R[rs] and read_data2 <= R[rt]. Read latency is 1 cycle.
  - When reg_read=0 or stall=1, both outputs hold their previous values.
- Write-to-read bypass: if a write commits on the same edge as a read of the same non-zero register, the read output captures the new write value.
  - This applies to both the rd path and the R14/CLL path.
- Stall=1 freezes the register array and both read outputs; exception still tracks its inputs.
- Reset asserted mid-operation clears all state immediately, with no clock needed. The first write or read may occur on the first rising edge after reset deasserts.
- An unknown reg_write_addr_sel must never be relied on; the bench drives it to 0 or 1 whenever reg_write=1.

Test Plan:
- Reset then write/read: reset=1 for 10 ns, then reg_write=1, rd=1, write_data=0x12345678, opcode=0, edge. Next, reg_read=1, rs=1, rt=0, edge -> read_data1=0x12345678, read_data2=0, exception=0.
- LDW odd Rd: opcode=8, rd=1, reg_write=1, write_data=0xDEADBEEF -> exception=1 and R1 stays 0x12345678. Repeat with rd=2 -> exception=0 and R2 is written.
- SDW odd Rd: opcode=9, rd=3 -> exception=1 and no register changes. With opcode=0 and rd=3 -> exception=0.
- CLL: opcode=15, reg_write_addr_sel=1, return_addr=0x000000FF, reg_write=1, edge. Next, reg_read=1, rs=14, edge -> read_data1=0x000000FF, and R[rd] is unchanged.
- R0 and bypass:
  - Write rd=0 with 0xFFFFFFFF -> reading R0 gives 0.
  - Write rd=5 with 0xA5A5A5A5 while rs=5 and reg_read=1 on the same edge -> read_data1=0xA5A5A5A5 after that edge.
- Stall and async reset:
  - stall=1 with reg_write=1, rd=6, write_data=0x55 -> R6 unchanged and read outputs held.
  - Then reset=1 between clock edges -> read_data1/read_data2 go to 0 immediately, and all registers read 0 afterward.

Source files
------------

// File: rtl/register_file.sv
// 16 x 32 register file with two registered read ports, one write port
// (rd or the link register R14 for CLL), write-to-read bypass and the
// odd-destination exception for LDW/SDW.
module register_file (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_read,
   input  logic [3:0]  rs,
   input  logic [3:0]  rt,
   input  logic [3:0]  rd,
   input  logic        reg_write,
   input  logic        reg_write_addr_sel,
   input  logic        stall,
   input  logic [5:0]  opcode,
   input  logic [31:0] write_data,
   input  logic [31:0] return_addr,
   output logic [31:0] read_data1,
   output logic [31:0] read_data2,
   output logic        exception
);

   localparam logic [3:0] LINK_REG = 4'd14;
   localparam logic [5:0] OP_LDW   = 6'd8;
   localparam logic [5:0] OP_SDW   = 6'd9;

   logic [31:0] regs [16];
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_value;
   logic        bypass1;
   logic        bypass2;
   logic [31:0] rd_value1;
   logic [31:0] rd_value2;

   // Exception tracks opcode/rd directly; forced low while reset is held.
   always_comb begin
      exception = 1'b0;
      if (!reset && (opcode == OP_LDW || opcode == OP_SDW) && rd[0])
         exception = 1'b1;
   end

   // Resolve the write target and whether a write commits this edge.
   // A write to R0 is treated as no write at all so it can never bypass.
   always_comb begin
      wr_addr  = reg_write_addr_sel ? LINK_REG : rd;
      wr_value = reg_write_addr_sel ? return_addr : write_data;
      wr_en    = reg_write && !stall && !exception && (wr_addr != 4'd0);
   end

   // Read mux with same-edge bypass from the committing write.
   always_comb begin
      bypass1   = wr_en && (wr_addr == rs);
      bypass2   = wr_en && (wr_addr == rt);
      rd_value1 = (rs == 4'd0) ? 32'd0 : regs[rs];
      rd_value2 = (rt == 4'd0) ? 32'd0 : regs[rt];
      if (bypass1)
         rd_value1 = wr_value;
      if (bypass2)
         rd_value2 = wr_value;
   end

   // Register array; R0 is never written and always reads as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++)
            regs[i] <= 32'd0;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_value;
      end
   end

   // Registered read ports; hold their value when not reading or stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_data1 <= 32'd0;
         read_data2 <= 32'd0;
      end else if (reg_read && !stall) begin
         read_data1 <= rd_value1;
         read_data2 <= rd_value2;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: hand-computed expected values.
module tb_register_file;

   logic        clk;
   logic        reset;
   logic        reg_read;
   logic [3:0]  rs;
   logic [3:0]  rt;
   logic [3:0]  rd;
   logic        reg_write;
   logic        reg_write_addr_sel;
   logic        stall;
   logic [5:0]  opcode;
   logic [31:0] write_data;
   logic [31:0] return_addr;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        exception;

   int n_vec;
   int n_err;

   register_file dut (
      .clk                (clk),
      .reset              (reset),
      .reg_read           (reg_read),
      .rs                 (rs),
      .rt                 (rt),
      .rd                 (rd),
      .reg_write          (reg_write),
      .reg_write_addr_sel (reg_write_addr_sel),
      .stall              (stall),
      .opcode             (opcode),
      .write_data         (write_data),
      .return_addr        (return_addr),
      .read_data1         (read_data1),
      .read_data2         (read_data2),
      .exception          (exception)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_read           = 1'b0;
      reg_write          = 1'b0;
      reg_write_addr_sel = 1'b0;
      stall              = 1'b0;
      opcode             = 6'd0;
   endtask

   task automatic do_read(input logic [3:0] a1, input logic [3:0] a2);
      idle();
      reg_read = 1'b1;
      rs       = a1;
      rt       = a2;
      step();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      idle();
      rs = 4'd0; rt = 4'd0; rd = 4'd0;
      write_data = 32'd0; return_addr = 32'd0;
      #1 reset = 1'b1;
      opcode = 6'd8; rd = 4'd1;
      #1;
      chk("rst_rd1", read_data1, 32'd0);
      chk("rst_rd2", read_data2, 32'd0);
      chk("rst_exc", {31'd0, exception}, 32'd0);
      opcode = 6'd0; rd = 4'd0;
      #10 reset = 1'b0;

      // basic write then read
      reg_write = 1'b1; rd = 4'd1; write_data = 32'h12345678;
      step();
      do_read(4'd1, 4'd0);
      chk("wr_rd1", read_data1, 32'h12345678);
      chk("wr_rd2", read_data2, 32'd0);
      chk("wr_exc", {31'd0, exception}, 32'd0);

      // LDW odd rd: exception, no write
      idle();
      opcode = 6'd8; rd = 4'd1; reg_write = 1'b1; write_data = 32'hDEADBEEF;
      #1 chk("ldw_odd_exc", {31'd0, exception}, 32'd1);
      step();
      rd = 4'd2;
      #1 chk("ldw_even_exc", {31'd0, exception}, 32'd0);
      step();
      do_read(4'd1, 4'd2);
      chk("ldw_r1_kept", read_data1, 32'h12345678);
      chk("ldw_r2_wr", read_data2, 32'hDEADBEEF);

      // SDW odd rd: exception, no write
      idle();
      opcode = 6'd9; rd = 4'd3; reg_write = 1'b1; write_data = 32'hCAFEF00D;
      #1 chk("sdw_odd_exc", {31'd0, exception}, 32'd1);
      step();
      reg_write = 1'b0; opcode = 6'd0;
      #1 chk("op0_odd_exc", {31'd0, exception}, 32'd0);
      do_read(4'd3, 4'd1);
      chk("sdw_r3_kept", read_data1, 32'd0);
      chk("sdw_r1_kept", read_data2, 32'h12345678);

      // CLL writes R14, not R[rd]
      idle();
      opcode = 6'd15; reg_write_addr_sel = 1'b1; reg_write = 1'b1;
      return_addr = 32'h000000FF; rd = 4'd2; write_data = 32'h11111111;
      step();
      do_read(4'd14, 4'd2);
      chk("cll_r14", read_data1, 32'h000000FF);
      chk("cll_rd_kept", read_data2, 32'hDEADBEEF);

      // R0 discards writes, even with a same-edge read
      idle();
      reg_write = 1'b1; rd = 4'd0; write_data = 32'hFFFFFFFF;
      reg_read = 1'b1; rs = 4'd0; rt = 4'd0;
      step();
      chk("r0_same_edge", read_data1, 32'd0);
      do_read(4'd0, 4'd0);
      chk("r0_rd1", read_data1, 32'd0);
      chk("r0_rd2", read_data2, 32'd0);

      // bypass on rd path
      idle();
      reg_write = 1'b1; rd = 4'd5; write_data = 32'hA5A5A5A5;
      reg_read = 1'b1; rs = 4'd5; rt = 4'd14;
      step();
      chk("byp_rd_rd1", read_data1, 32'hA5A5A5A5);
      chk("byp_rd_rd2", read_data2, 32'h000000FF);

      // bypass on CLL path (rt side too)
      idle();
      reg_write = 1'b1; reg_write_addr_sel = 1'b1; return_addr = 32'h00001234;
      reg_read = 1'b1; rs = 4'd14; rt = 4'd5;
      step();
      chk("byp_cll_rd1", read_data1, 32'h00001234);
      chk("byp_cll_rd2", read_data2, 32'hA5A5A5A5);
      idle();
      reg_write = 1'b1; rd = 4'd7; write_data = 32'h0BADF00D;
      reg_read = 1'b1; rs = 4'd14; rt = 4'd7;
      step();
      chk("byp_rt_rd2", read_data2, 32'h0BADF00D);
      chk("byp_rt_rd1", read_data1, 32'h00001234);

      // reg_read=0 holds outputs
      idle();
      rs = 4'd1; rt = 4'd2;
      step();
      chk("hold_rd1", read_data1, 32'h00001234);
      chk("hold_rd2", read_data2, 32'h0BADF00D);

      // stall freezes writes and reads; exception still tracks
      idle();
      stall = 1'b1; reg_write = 1'b1; rd = 4'd6; write_data = 32'h00000055;
      reg_read = 1'b1; rs = 4'd6; rt = 4'd1;
      step();
      chk("stall_rd1", read_data1, 32'h00001234);
      chk("stall_rd2", read_data2, 32'h0BADF00D);
      opcode = 6'd8; rd = 4'd7;
      #1 chk("stall_exc", {31'd0, exception}, 32'd1);
      step();
      do_read(4'd6, 4'd1);
      chk("stall_r6", read_data1, 32'd0);
      chk("stall_r1", read_data2, 32'h12345678);

      // async reset between edges
      do_read(4'd5, 4'd14);
      chk("pre_rst_rd1", read_data1, 32'hA5A5A5A5);
      chk("pre_rst_rd2", read_data2, 32'h00001234);
      @(negedge clk);
      #1 reset = 1'b1;
      opcode = 6'd8; rd = 4'd1;
      #1;
      chk("arst_rd1", read_data1, 32'd0);
      chk("arst_rd2", read_data2, 32'd0);
      chk("arst_exc", {31'd0, exception}, 32'd0);
      #1 reset = 1'b0;
      opcode = 6'd0; rd = 4'd0;
      for (int i = 1; i < 16; i++) begin
         do_read(i[3:0], i[3:0]);
         chk($sformatf("clr_r%0d_p1", i), read_data1, 32'd0);
         chk($sformatf("clr_r%0d_p2", i), read_data2, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
